reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/riscv_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 63 ++++++
 rtl/reg_file.sv | 69 ++++++
 tb/tb_reg_file.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core parameters and small helpers used by the register file.
package riscv_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREG   = 32;
   localparam int NADDR  = 1 << REG_AW;

   typedef logic [REG_AW-1:0] reg_addr_t;

   function automatic logic [NADDR-1:0] reg_onehot(input reg_addr_t a);
      logic [NADDR-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: busy marks, set/clear/flush and issue hazard.
// REG_FILE_BYPASS_EN lets a same-cycle commit hide its busy mark from the hazard check.
module reg_scoreboard
   import riscv_pkg::*;
#(
   parameter int NREG = riscv_pkg::NREG
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            commit,
   input  reg_addr_t       wb_rd,
   input  reg_addr_t       rs1_addr,
   input  reg_addr_t       rs2_addr,
   input  logic            rs1_use,
   input  logic            rs2_use,
   input  logic            iss_valid,
   input  reg_addr_t       iss_rd,
   input  logic            flush,
   output logic            hazard,
   output logic [NREG-1:0] busy_vec
);

   logic [NREG-1:0]  busy_q, busy_d;
   logic [NREG-1:0]  clr_vec, set_vec, busy_eff;
   logic [NADDR-1:0] clr_full, set_full, beff_full;
   logic             issue;

   always_comb begin
      clr_full = commit ? reg_onehot(wb_rd) : '0;
      clr_vec  = clr_full[NREG-1:0];

`ifdef REG_FILE_BYPASS_EN
      busy_eff = busy_q & ~clr_vec;
`else
      busy_eff = busy_q;
`endif

      // Zero-extend so any 5-bit address indexes safely even when NREG < 32.
      beff_full           = '0;
      beff_full[NREG-1:0] = busy_eff;

      hazard = (rs1_use   & beff_full[rs1_addr]) |
               (rs2_use   & beff_full[rs2_addr]) |
               (iss_valid & beff_full[iss_rd]);

      issue    = iss_valid & ~hazard & (iss_rd != '0) & ~flush;
      set_full = issue ? reg_onehot(iss_rd) : '0;
      set_vec  = set_full[NREG-1:0];

      // Set is applied after clear so a same-cycle issue keeps its mark.
      if (flush) busy_d = '0;
      else       busy_d = (busy_q & ~clr_vec) | set_vec;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file.sv
// Architectural integer register file (x0 hard-wired zero) with write-back scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module reg_file
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter int NREG = riscv_pkg::NREG
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_en,
   input  logic            wb_stall,
   input  reg_addr_t       wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  reg_addr_t       rs1_addr,
   input  reg_addr_t       rs2_addr,
   input  logic            rs1_use,
   input  logic            rs2_use,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            iss_valid,
   input  reg_addr_t       iss_rd,
   input  logic            flush,
   output logic            hazard,
   output logic [NREG-1:0] busy_vec
);

   logic [XLEN-1:0] regs [NREG];
   logic            commit;

   // A stalled write-back stage is ignored entirely.
   assign commit = wb_en & ~wb_stall & (wb_rd != '0) & (int'(wb_rd) < NREG);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (commit) begin
         regs[wb_rd] <= wb_data;
      end
   end

   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1_addr != '0 && int'(rs1_addr) < NREG) rs1_data = regs[rs1_addr];
      if (rs2_addr != '0 && int'(rs2_addr) < NREG) rs2_data = regs[rs2_addr];
`ifdef REG_FILE_BYPASS_EN
      if (commit && wb_rd == rs1_addr) rs1_data = wb_data;
      if (commit && wb_rd == rs2_addr) rs2_data = wb_data;
`endif
   end

   reg_scoreboard #(.NREG(NREG)) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .commit    (commit),
      .wb_rd     (wb_rd),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_use   (rs1_use),
      .rs2_use   (rs2_use),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .flush     (flush),
      .hazard    (hazard),
      .busy_vec  (busy_vec)
   );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// against an array-based register/busy model.
module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_en, wb_stall, rs1_use, rs2_use, iss_valid, flush;
   logic [4:0]  wb_rd, rs1_addr, rs2_addr, iss_rd;
   logic [31:0] wb_data, rs1_data, rs2_data, busy_vec;
   logic        hazard;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mregs [32];
   logic [31:0] mbusy;

   reg_file dut (
      .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_stall(wb_stall), .wb_rd(wb_rd),
      .wb_data(wb_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_use(rs1_use),
      .rs2_use(rs2_use), .rs1_data(rs1_data), .rs2_data(rs2_data), .iss_valid(iss_valid),
      .iss_rd(iss_rd), .flush(flush), .hazard(hazard), .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit m_commit();
      return wb_en && !wb_stall && wb_rd != 5'd0;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (BYP && m_commit() && wb_rd == a) return wb_data;
      return mregs[a];
   endfunction

   function automatic bit m_hazard();
      logic [31:0] b;
      b = mbusy;
      if (BYP && m_commit()) b[wb_rd] = 1'b0;
      return (rs1_use && b[rs1_addr]) || (rs2_use && b[rs2_addr]) || (iss_valid && b[iss_rd]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mbusy = 32'd0;
   endtask

   task automatic idle();
      wb_en = 0; wb_stall = 0; wb_rd = 0; wb_data = 0;
      rs1_addr = 0; rs2_addr = 0; rs1_use = 0; rs2_use = 0;
      iss_valid = 0; iss_rd = 0; flush = 0;
   endtask

   // Entered just after a rising edge with inputs already driven.
   task automatic cycle(input string tag);
      bit          hz, cm, iv, fl;
      logic [4:0]  rd, ir;
      logic [31:0] d;
      #1;
      hz = m_hazard();
      chk({tag, ".rs1"}, rs1_data, m_read(rs1_addr));
      chk({tag, ".rs2"}, rs2_data, m_read(rs2_addr));
      chk({tag, ".hz"}, {31'd0, hazard}, {31'd0, hz});
      cm = m_commit(); rd = wb_rd; d = wb_data; iv = iss_valid; ir = iss_rd; fl = flush;
      @(posedge clk);
      if (cm) mregs[rd] = d;
      if (fl) mbusy = 32'd0;
      else begin
         if (cm) mbusy[rd] = 1'b0;
         if (iv && !hz && ir != 5'd0) mbusy[ir] = 1'b1;
      end
      #1;
      chk({tag, ".busy"}, busy_vec, mbusy);
   endtask

   initial begin
      idle();
      model_reset();
      rst_n = 0;
      #12;
      rs1_addr = 5; rs1_use = 1; iss_valid = 1; iss_rd = 7;
      #1;
      chk("rst.rs1", rs1_data, 32'd0);
      chk("rst.busy", busy_vec, 32'd0);
      chk("rst.hz", {31'd0, hazard}, 32'd0);
      idle();
      rst_n = 1;
      @(posedge clk); #1;

      // write x5, then read it back
      wb_en = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; cycle("wr5");
      idle(); rs1_addr = 5; rs1_use = 1; #1;
      chk("rd5", rs1_data, 32'hDEADBEEF);
      cycle("rd5c");

      // x0 write is discarded
      idle(); wb_en = 1; wb_rd = 0; wb_data = 32'h1234; cycle("wr0");
      idle(); #1;
      chk("rd0.rs1", rs1_data, 32'd0);
      chk("rd0.rs2", rs2_data, 32'd0);
      cycle("rd0c");

      // RAW dependency on x7
      idle(); iss_valid = 1; iss_rd = 7; cycle("iss7");
      idle(); rs2_addr = 7; rs2_use = 1; #1;
      chk("dep7.hz", {31'd0, hazard}, 32'd1);
      cycle("dep7a");
      cycle("dep7b");
      wb_en = 1; wb_rd = 7; wb_data = 32'hA5A50007; #1;
      if (BYP) begin
         chk("byp7.hz", {31'd0, hazard}, 32'd0);
         chk("byp7.rs2", rs2_data, 32'hA5A50007);
      end else begin
         chk("nobyp7.hz", {31'd0, hazard}, 32'd1);
      end
      cycle("wb7");
      idle(); rs2_addr = 7; rs2_use = 1; #1;
      chk("post7.hz", {31'd0, hazard}, 32'd0);
      chk("post7.rs2", rs2_data, 32'hA5A50007);
      cycle("post7c");

      // same-cycle issue and commit of x3: set wins
      idle(); iss_valid = 1; iss_rd = 3; wb_en = 1; wb_rd = 3; wb_data = 32'h55;
      cycle("setwin");
      chk("setwin.busy3", {31'd0, busy_vec[3]}, 32'd1);
      idle(); rs1_addr = 3; #1;
      chk("setwin.x3", rs1_data, 32'h55);

      // stalled write-back is ignored
      idle(); iss_valid = 1; iss_rd = 9; cycle("iss9");
      idle(); wb_en = 1; wb_stall = 1; wb_rd = 9; wb_data = 32'hFF; rs1_addr = 9;
      cycle("stall9");
      chk("stall9.busy9", {31'd0, busy_vec[9]}, 32'd1);
      idle(); rs1_addr = 9; #1;
      chk("stall9.x9", rs1_data, 32'd0);

      // drain, build 0xF0, then flush with concurrent issue of x2
      idle(); wb_en = 1; wb_rd = 3; wb_data = 32'h33; cycle("drain3");
      idle(); wb_en = 1; wb_rd = 9; wb_data = 32'h99; cycle("drain9");
      for (int r = 4; r < 8; r++) begin
         idle(); iss_valid = 1; iss_rd = 5'(r); cycle("isshi");
      end
      chk("pre_flush.busy", busy_vec, 32'h0000_00F0);
      idle(); flush = 1; iss_valid = 1; iss_rd = 2; cycle("flush");
      chk("flush.busy", busy_vec, 32'd0);

      // randomized traffic; small address range to provoke collisions
      for (int n = 0; n < 400; n++) begin
         wb_en = 1'($urandom); wb_stall = ($urandom % 4) == 0;
         wb_rd = 5'($urandom % 12); wb_data = $urandom;
         rs1_addr = 5'($urandom % 12); rs2_addr = 5'($urandom % 12);
         rs1_use = 1'($urandom); rs2_use = 1'($urandom);
         iss_valid = 1'($urandom); iss_rd = 5'($urandom % 12);
         flush = ($urandom % 16) == 0;
         cycle("rnd");
      end

      // asynchronous reset mid-cycle
      idle(); wb_en = 1; wb_rd = 11; wb_data = 32'h1111; iss_valid = 1; iss_rd = 6; cycle("prerst");
      idle(); rs1_addr = 11; rs1_use = 1; rs2_addr = 6; rs2_use = 1;
      #1;
      rst_n = 0;
      #1;
      chk("arst.rs1", rs1_data, 32'd0);
      chk("arst.rs2", rs2_data, 32'd0);
      chk("arst.busy", busy_vec, 32'd0);
      chk("arst.hz", {31'd0, hazard}, 32'd0);
      model_reset();
      #1 rst_n = 1;
      @(posedge clk); #1;
      idle(); rs1_addr = 11; rs1_use = 1; cycle("postrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
